// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the ALU front-end sequencer.
// State codes are exported on the board display, so their values are fixed.
package alu_seq_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int OPW_DEF   = 3;

   typedef enum logic [2:0] {
      S_A     = 3'd0,
      S_B     = 3'd1,
      S_OP    = 3'd2,
      S_ISSUE = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   localparam logic [31:0] OP_MIN       = 32'd0;
   localparam logic [31:0] OP_MAX_LEGAL = 32'd5;
   localparam logic [31:0] OP_RSVD_MIN  = 32'd6;

   // Op selects at or above OP_RSVD_MIN have no ALU meaning and abort the step.
   function automatic logic opIsReserved(input logic [31:0] op);
      return (op >= OP_RSVD_MIN);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// Push-button front end: 2-FF synchronizer, stability counter and rising-edge pulse.
// press_o is a single registered cycle per accepted press.
module btn_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic clear,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;

   // The level only flips after DB_CYCLES consecutive differing samples; the
   // pulse is raised in the same edge the level rises, so it cannot repeat.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_q <= sync2_q;
            press_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the 16-bit ALU: collects A, B and op on debounced presses,
// issues one start pulse, waits for valid with a timeout and holds the result.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int OPW       = OPW_DEF,
   parameter int DB_CYCLES = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             next,
   input  logic [OPW-1:0]   ms,
   input  logic [WIDTH-1:0] din,
   input  logic             alu_valid,
   input  logic [WIDTH-1:0] alu_result,
   output logic             alu_start,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   output logic             done_out,
   output logic             err_out,
   output logic [2:0]       cs_out,
   output logic [WIDTH-1:0] result_out
);

   localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e           state_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [OPW-1:0]   opSel_q;
   logic [WIDTH-1:0] result_q;
   logic             err_q;
   logic [TCW-1:0]   tmoCnt_q;
   logic [TCW-1:0]   tmoCnt_d;
   logic             press;

   btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) uDebounce (
      .clk    (clk),
      .clear  (clear),
      .btn_i  (next),
      .press_o(press)
   );

   assign tmoCnt_d = tmoCnt_q + TCW'(1);

   // Presses are only looked at in the collection states and S_DONE, so a
   // press during ISSUE/WAIT is simply dropped; alu_valid only counts in WAIT.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= S_A;
         opA_q    <= '0;
         opB_q    <= '0;
         opSel_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         tmoCnt_q <= '0;
      end else begin
         case (state_q)
            S_A: begin
               if (press) begin
                  opA_q   <= din;
                  state_q <= S_B;
               end
            end
            S_B: begin
               if (press) begin
                  opB_q   <= din;
                  state_q <= S_OP;
               end
            end
            S_OP: begin
               if (press) begin
                  opSel_q <= ms;
                  if (opIsReserved(32'(ms))) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               err_q    <= 1'b0;
               tmoCnt_q <= '0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (alu_valid) begin
                  result_q <= alu_result;
                  state_q  <= S_DONE;
               end else if (tmoCnt_q == TCW'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  tmoCnt_q <= tmoCnt_d;
               end
            end
            S_DONE: begin
               if (press) begin
                  state_q <= S_A;
               end
            end
            default: begin
               state_q <= S_A;
            end
         endcase
      end
   end

   assign alu_start  = (state_q == S_ISSUE);
   assign done_out   = (state_q == S_DONE);
   assign cs_out     = state_q;
   assign alu_a      = opA_q;
   assign alu_b      = opB_q;
   assign alu_op     = opSel_q;
   assign err_out    = err_q;
   assign result_out = result_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_alu_seq_ctrl;

   localparam int WIDTH     = 16;
   localparam int OPW       = 3;
   localparam int DB_CYCLES = 4;
   localparam int TIMEOUT   = 64;

   localparam logic [2:0] CS_A     = 3'd0;
   localparam logic [2:0] CS_B     = 3'd1;
   localparam logic [2:0] CS_OP    = 3'd2;
   localparam logic [2:0] CS_WAIT  = 3'd4;
   localparam logic [2:0] CS_DONE  = 3'd5;

   logic             clk = 1'b0;
   logic             clear;
   logic             next;
   logic [OPW-1:0]   ms;
   logic [WIDTH-1:0] din;
   logic             alu_valid = 1'b0;
   logic [WIDTH-1:0] alu_result = '0;
   logic             alu_start;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic             done_out;
   logic             err_out;
   logic [2:0]       cs_out;
   logic [WIDTH-1:0] result_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(
      .WIDTH    (WIDTH),
      .OPW      (OPW),
      .DB_CYCLES(DB_CYCLES),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .next      (next),
      .ms        (ms),
      .din       (din),
      .alu_valid (alu_valid),
      .alu_result(alu_result),
      .alu_start (alu_start),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .done_out  (done_out),
      .err_out   (err_out),
      .cs_out    (cs_out),
      .result_out(result_out)
   );

   // Behaviour of the ALU being sequenced
   function automatic logic [WIDTH-1:0] aluFunc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [OPW-1:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         default: return '0;
      endcase
   endfunction

   // ALU model: valid arrives aluLatency cycles after the start cycle; 0 means never.
   int               aluLatency = 0;
   int               countdown = 0;
   logic [WIDTH-1:0] pendingResult = '0;

   always @(negedge clk) begin
      if (countdown > 0) begin
         countdown = countdown - 1;
         alu_valid = (countdown == 0);
      end else begin
         alu_valid = 1'b0;
      end
      alu_result = alu_valid ? pendingResult : WIDTH'($urandom);
      if (alu_start === 1'b1 && aluLatency > 0) begin
         countdown     = aluLatency;
         pendingResult = aluFunc(alu_a, alu_b, alu_op);
      end
   end

   // Running counts of start-pulse cycles and cycles spent in S_WAIT
   int startCount = 0;
   int waitCount  = 0;

   always @(negedge clk) begin
      if (alu_start === 1'b1) startCount = startCount + 1;
      if (cs_out === CS_WAIT) waitCount = waitCount + 1;
   end

   int startBase;
   int waitBase;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OPW-1:0]   op;
      int               lat;
      logic [WIDTH-1:0] expRes;
      logic             expErr;
      int               expStarts;
      int               expWait;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pressButton(input int highCycles);
      next = 1'b1;
      repeat (highCycles) @(posedge clk);
      #1;
      next = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (done_out !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done_out !== 1'b1) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL done_wait actual=cs%0d expected=done within 300 cycles", cs_out);
      end
   endtask

   task automatic issueOp(input logic [OPW-1:0] op, input int lat);
      aluLatency = lat;
      startBase  = startCount;
      waitBase   = waitCount;
      ms         = op;
      pressButton(12);
      waitDone();
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [OPW-1:0] op, input int lat);
      if (cs_out == CS_DONE) pressButton(12);
      din = a;
      pressButton(12);
      din = b;
      pressButton(12);
      issueOp(op, lat);
   endtask

   task automatic checkOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [OPW-1:0] op, input logic [WIDTH-1:0] res, input logic err,
                          input int starts, input int waits);
      checkOutput({tag, "_cs"}, cs_out, CS_DONE);
      checkOutput({tag, "_done"}, done_out, 1'b1);
      checkOutput({tag, "_start_idle"}, alu_start, 1'b0);
      checkOutput({tag, "_err"}, err_out, err);
      checkOutput({tag, "_result"}, result_out, res);
      checkOutput({tag, "_alu_a"}, alu_a, a);
      checkOutput({tag, "_alu_b"}, alu_b, b);
      checkOutput({tag, "_alu_op"}, alu_op, op);
      checkOutput({tag, "_starts"}, startCount - startBase, starts);
      checkOutput({tag, "_wait_cycles"}, waitCount - waitBase, waits);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [OPW-1:0]   rop;
      logic [WIDTH-1:0] expRes;
      logic [WIDTH-1:0] prevRes;
      logic             expErr;
      int               rlat;
      int               expStarts;
      int               expWait;
      int               k;

      vecs[0] = '{16'h0001, 16'h0003, 3'd1, 3,           16'h0004, 1'b0, 1, 3};
      vecs[1] = '{16'h0005, 16'h0007, 3'd6, 5,           16'h0000, 1'b1, 0, 0};
      vecs[2] = '{16'h1234, 16'h0F0F, 3'd4, 1,           16'h1D3B, 1'b0, 1, 1};
      vecs[3] = '{16'h0009, 16'h0002, 3'd2, 0,           16'h1D3B, 1'b1, 1, TIMEOUT};
      vecs[4] = '{16'd100,  16'd50,   3'd1, TIMEOUT,     16'd150,  1'b0, 1, TIMEOUT};
      vecs[5] = '{16'hFFFF, 16'h0001, 3'd1, TIMEOUT + 1, 16'd150,  1'b1, 1, TIMEOUT};
      vecs[6] = '{16'h0003, 16'h0004, 3'd7, 1,           16'h0000, 1'b1, 0, 0};
      vecs[7] = '{16'hAAAA, 16'h5555, 3'd3, 2,           16'hFFFF, 1'b0, 1, 2};
      vecs[8] = '{16'h00F0, 16'h0000, 3'd5, 1,           16'hFF0F, 1'b0, 1, 1};
      vecs[9] = '{16'hF0F0, 16'hFF00, 3'd0, 5,           16'hF000, 1'b0, 1, 5};

      clear = 1'b1;
      next  = 1'b0;
      ms    = '0;
      din   = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cs", cs_out, CS_A);
      checkOutput("reset_done", done_out, 1'b0);
      checkOutput("reset_err", err_out, 1'b0);
      checkOutput("reset_result", result_out, 16'h0);
      checkOutput("reset_start", alu_start, 1'b0);
      checkOutput("reset_alu_a", alu_a, 16'h0);
      checkOutput("reset_alu_b", alu_b, 16'h0);
      checkOutput("reset_alu_op", alu_op, 3'd0);
      clear = 1'b0;
      @(posedge clk);
      #1;

      // Glitch one cycle shorter than the debounce window: no transition
      din  = 16'h0077;
      next = 1'b1;
      repeat (DB_CYCLES - 1) @(posedge clk);
      #1;
      next = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("glitch_cs", cs_out, CS_A);

      // Bouncy press: exactly one A->B transition
      next = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      next = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pressButton(20);
      checkOutput("bounce_cs", cs_out, CS_B);
      checkOutput("bounce_alu_a", alu_a, 16'h0077);

      // Clean press latency from next rising to the state change
      din  = 16'h0099;
      next = 1'b1;
      k    = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         k++;
         if (cs_out != CS_B) break;
      end
      checkOutput("press_latency", k, 2 + DB_CYCLES + 1);
      checkOutput("latency_cs", cs_out, CS_OP);
      checkOutput("latency_alu_b", alu_b, 16'h0099);
      repeat (10) @(posedge clk);
      #1;
      next = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      issueOp(3'd1, 3);
      checkOp("first_add", 16'h0077, 16'h0099, 3'd1, 16'h0110, 1'b0, 1, 3);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lat);
         checkOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].expRes,
                 vecs[i].expErr, vecs[i].expStarts, vecs[i].expWait);
      end

      // Press while waiting is dropped and not replayed later
      pressButton(12);
      din = 16'h0010;
      pressButton(12);
      din = 16'h0020;
      pressButton(12);
      aluLatency = 0;
      startBase  = startCount;
      waitBase   = waitCount;
      ms         = 3'd1;
      pressButton(12);
      pressButton(12);
      checkOutput("drop_press_cs", cs_out, CS_WAIT);
      waitDone();
      repeat (20) @(posedge clk);
      #1;
      checkOp("drop_press", 16'h0010, 16'h0020, 3'd1, 16'hF000, 1'b1, 1, TIMEOUT);

      // Reset while waiting, with the ALU answer still in flight
      applyStimulus(16'h0001, 16'h0002, 3'd1, 40);
      checkOutput("midreset_pre_cs", cs_out, CS_DONE);
      pressButton(12);
      din = 16'h0004;
      pressButton(12);
      din = 16'h0005;
      pressButton(12);
      aluLatency = 40;
      ms         = 3'd1;
      pressButton(12);
      checkOutput("midreset_wait_cs", cs_out, CS_WAIT);
      @(negedge clk);
      clear = 1'b1;
      #1;
      checkOutput("midreset_cs", cs_out, CS_A);
      checkOutput("midreset_done", done_out, 1'b0);
      checkOutput("midreset_err", err_out, 1'b0);
      checkOutput("midreset_result", result_out, 16'h0);
      checkOutput("midreset_alu_a", alu_a, 16'h0);
      checkOutput("midreset_alu_b", alu_b, 16'h0);
      checkOutput("midreset_alu_op", alu_op, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      clear = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("late_valid_cs", cs_out, CS_A);
      checkOutput("late_valid_result", result_out, 16'h0);

      // Randomized operations against a transaction-level model
      prevRes = '0;
      for (int i = 0; i < 12; i++) begin
         ra  = WIDTH'($urandom);
         rb  = WIDTH'($urandom);
         rop = OPW'($urandom_range(0, 7));
         k   = $urandom_range(0, 9);
         if (k <= 6) rlat = k;
         else if (k == 7) rlat = TIMEOUT;
         else if (k == 8) rlat = TIMEOUT + 1;
         else rlat = $urandom_range(10, 40);
         if (rop >= 3'd6) begin
            expRes = '0;
            expErr = 1'b1;
            expStarts = 0;
            expWait = 0;
         end else if (rlat == 0 || rlat > TIMEOUT) begin
            expRes = prevRes;
            expErr = 1'b1;
            expStarts = 1;
            expWait = TIMEOUT;
         end else begin
            expRes = aluFunc(ra, rb, rop);
            expErr = 1'b0;
            expStarts = 1;
            expWait = rlat;
         end
         prevRes = expRes;
         applyStimulus(ra, rb, rop, rlat);
         checkOp($sformatf("rand%0d", i), ra, rb, rop, expRes, expErr, expStarts, expWait);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
